// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: data width,
// reset PC and the data-wait FSM state encoding.
package pipeline_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    PCTL_RUN   = 1'b0,
    PCTL_DWAIT = 1'b1
  } pctl_state_e;

  function automatic logic src_match(input logic uses, input logic [4:0] src, input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush/redirect outputs between the pipeline and
// its central controller. The controller sits on the slave modport.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [4:0]                         id_rs1_addr;
  logic [4:0]                         id_rs2_addr;
  logic                               id_uses_rs1;
  logic                               id_uses_rs2;
  logic                               ex_MemRead;
  logic [4:0]                         ex_rd_addr;
  logic                               mem_MemRead;
  logic                               mem_MemWrite;
  logic                               mem_branch_taken;
  logic [pipeline_ctrl_pkg::XLEN-1:0] mem_branch_target;
  logic                               imem_ready;
  logic                               dmem_ready;

  logic                               pc_stall;
  logic                               pc_redirect;
  logic [pipeline_ctrl_pkg::XLEN-1:0] pc_target;
  logic                               if_id_stall;
  logic                               if_id_flush;
  logic                               id_ex_stall;
  logic                               id_ex_flush;
  logic                               ex_mem_stall;
  logic                               ex_mem_flush;
  logic                               mem_wb_stall;
  logic                               mem_wb_flush;
  logic                               dmem_req;
  logic                               dmem_timeout;
  logic [CNT_W-1:0]                   bubble_count;
  logic [CNT_W-1:0]                   redirect_count;
  logic [CNT_W-1:0]                   freeze_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_MemRead, ex_rd_addr, mem_MemRead, mem_MemWrite,
           mem_branch_taken, mem_branch_target, imem_ready, dmem_ready,
    input  pc_stall, pc_redirect, pc_target, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
           mem_wb_stall, mem_wb_flush, dmem_req, dmem_timeout,
           bubble_count, redirect_count, freeze_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_MemRead, ex_rd_addr, mem_MemRead, mem_MemWrite,
           mem_branch_taken, mem_branch_target, imem_ready, dmem_ready,
    output pc_stall, pc_redirect, pc_target, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
           mem_wb_stall, mem_wb_flush, dmem_req, dmem_timeout,
           bubble_count, redirect_count, freeze_count
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, MEM-stage redirects,
// fetch waits and data-memory waits with a timeout watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 16,
  parameter int WC_W         = $clog2(DMEM_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  pipeline_ctrl_if.slave    bus,
  output pctl_state_e       o_dbg_state,
  output logic [WC_W-1:0]   o_dbg_wait_cnt
);

  localparam logic [WC_W-1:0] TMO = WC_W'(DMEM_TIMEOUT);

  pctl_state_e     r_state;
  pctl_state_e     w_next_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_next_wait_cnt;
  logic            r_dmem_timeout;
  logic            w_mem_acc;
  logic            w_abort;
  logic            w_freeze;
  logic            w_load_use;
  logic            w_branch_win;
  logic            w_bubble_win;
  logic            w_freeze_cnt;

  assign w_mem_acc  = bus.mem_MemRead | bus.mem_MemWrite;
  assign w_abort    = (r_state == PCTL_DWAIT) && (r_wait_cnt == TMO) && !bus.dmem_ready;
  assign w_freeze   = w_mem_acc && !bus.dmem_ready && !w_abort;
  assign w_load_use = bus.ex_MemRead && (bus.ex_rd_addr != 5'd0) &&
                      (src_match(bus.id_uses_rs1, bus.id_rs1_addr, bus.ex_rd_addr) ||
                       src_match(bus.id_uses_rs2, bus.id_rs2_addr, bus.ex_rd_addr));

  // Counters record which rule won the priority, so freeze masks the rest.
  assign w_branch_win = !reset && !w_freeze && bus.mem_branch_taken;
  assign w_bubble_win = !reset && !w_freeze && !bus.mem_branch_taken && w_load_use;
  assign w_freeze_cnt = !reset && w_freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= PCTL_RUN;
      r_wait_cnt     <= '0;
      r_dmem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (w_abort) begin
        r_dmem_timeout <= 1'b1;
      end
    end
  end

  // Leaving DWAIT covers completion, abort and the unexpected loss of mem_acc.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      PCTL_RUN: begin
        if (w_freeze) begin
          w_next_state    = PCTL_DWAIT;
          w_next_wait_cnt = WC_W'(1);
        end else begin
          w_next_wait_cnt = '0;
        end
      end
      PCTL_DWAIT: begin
        if (w_freeze) begin
          w_next_wait_cnt = r_wait_cnt + 1'b1;
        end else begin
          w_next_state    = PCTL_RUN;
          w_next_wait_cnt = '0;
        end
      end
      default: begin
        w_next_state    = PCTL_RUN;
        w_next_wait_cnt = '0;
      end
    endcase
  end

  always_comb begin
    bus.pc_stall     = 1'b0;
    bus.pc_redirect  = 1'b0;
    bus.if_id_stall  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_stall  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_stall = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.mem_wb_stall = 1'b0;
    bus.mem_wb_flush = 1'b0;
    if (!reset) begin
      if (w_freeze) begin
        bus.pc_stall     = 1'b1;
        bus.if_id_stall  = 1'b1;
        bus.id_ex_stall  = 1'b1;
        bus.ex_mem_stall = 1'b1;
        bus.mem_wb_flush = 1'b1;
      end else begin
        // An aborted access is dropped but the front of the pipe still moves.
        if (w_abort) begin
          bus.mem_wb_flush = 1'b1;
        end
        if (bus.mem_branch_taken) begin
          bus.pc_redirect  = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_flush  = 1'b1;
          bus.ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
          bus.pc_stall    = 1'b1;
          bus.if_id_stall = 1'b1;
          bus.id_ex_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          bus.pc_stall    = 1'b1;
          bus.if_id_flush = 1'b1;
        end
      end
    end
  end

  assign bus.pc_target    = bus.mem_branch_target;
  assign bus.dmem_req     = w_mem_acc;
  assign bus.dmem_timeout = r_dmem_timeout;
  assign o_dbg_state      = r_state;
  assign o_dbg_wait_cnt   = r_wait_cnt;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble_win),
    .count (bus.bubble_count)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_branch_win),
    .count (bus.redirect_count)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_freeze_cnt),
    .count (bus.freeze_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand-written multi-cycle
// sequences and random traffic, all checked against a rule-level model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int T    = 4;
  localparam int CW   = 2;
  localparam int WCW  = $clog2(T + 1);
  localparam int MAXC = (1 << CW) - 1;

  // Control bit order: pc_stall, pc_redirect, if_id stall/flush, id_ex stall/flush,
  // ex_mem stall/flush, mem_wb stall/flush.
  localparam logic [9:0] C_NONE = 10'b00_00_00_00_00;
  localparam logic [9:0] C_LU   = 10'b10_10_01_00_00;
  localparam logic [9:0] C_BR   = 10'b01_01_01_01_00;
  localparam logic [9:0] C_IM   = 10'b10_01_00_00_00;
  localparam logic [9:0] C_FZ   = 10'b10_10_10_10_01;
  localparam logic [9:0] C_AB   = 10'b00_00_00_00_01;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic        m_rd;
    logic        m_wr;
    logic        br;
    logic [31:0] tgt;
    logic        imem_rdy;
    logic        dmem_rdy;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [9:0] exp_ctrl;
  } vec_t;

  logic              clk;
  logic              reset;
  pctl_state_e       dbg_state;
  logic [WCW-1:0]    dbg_wait_cnt;
  logic [9:0]        w_ctrl;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(
    .DMEM_TIMEOUT (T),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_wait_cnt (dbg_wait_cnt)
  );

  assign w_ctrl = {bus.pc_stall, bus.pc_redirect, bus.if_id_stall, bus.if_id_flush,
                   bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall, bus.ex_mem_flush,
                   bus.mem_wb_stall, bus.mem_wb_flush};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the test finished");
    $fatal(1);
  end

  int total;
  int bad;
  int m_waited;
  int m_tmo;
  int m_bub;
  int m_red;
  int m_frz;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs1 = 5'd0; s.rs2 = 5'd0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.ex_mr = 1'b0; s.ex_rd = 5'd0; s.m_rd = 1'b0; s.m_wr = 1'b0; s.br = 1'b0;
    s.tgt = 32'h0; s.imem_rdy = 1'b1; s.dmem_rdy = 1'b1;
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // driver
  task automatic apply(input stim_t s);
    reset                 = s.rst;
    bus.id_rs1_addr       = s.rs1;
    bus.id_rs2_addr       = s.rs2;
    bus.id_uses_rs1       = s.u1;
    bus.id_uses_rs2       = s.u2;
    bus.ex_MemRead        = s.ex_mr;
    bus.ex_rd_addr        = s.ex_rd;
    bus.mem_MemRead       = s.m_rd;
    bus.mem_MemWrite      = s.m_wr;
    bus.mem_branch_taken  = s.br;
    bus.mem_branch_target = s.tgt;
    bus.imem_ready        = s.imem_rdy;
    bus.dmem_ready        = s.dmem_rdy;
  endtask

  // One cycle: drive, check every output against the model, advance the model.
  task automatic step(input stim_t s);
    logic       mem_acc;
    logic       abort;
    logic       freeze;
    logic       lu;
    logic [9:0] ec;
    @(negedge clk);
    apply(s);
    #1;
    mem_acc = s.m_rd | s.m_wr;
    abort   = (m_waited == T) && !s.dmem_rdy;
    freeze  = mem_acc && !s.dmem_rdy && !abort;
    lu      = s.ex_mr && (s.ex_rd != 5'd0) &&
              ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd));
    if (s.rst) ec = C_NONE;
    else if (freeze) ec = C_FZ;
    else begin
      ec = abort ? C_AB : C_NONE;
      if (s.br) ec = ec | C_BR;
      else if (lu) ec = ec | C_LU;
      else if (!s.imem_rdy) ec = ec | C_IM;
    end
    chk("ctrl", 32'(w_ctrl), 32'(ec));
    chk("pc_target", bus.pc_target, s.tgt);
    chk("dmem_req", 32'(bus.dmem_req), 32'(mem_acc));
    chk("dmem_timeout", 32'(bus.dmem_timeout), m_tmo);
    chk("bubble_count", 32'(bus.bubble_count), m_bub);
    chk("redirect_count", 32'(bus.redirect_count), m_red);
    chk("freeze_count", 32'(bus.freeze_count), m_frz);
    chk("state", 32'(dbg_state), (m_waited > 0) ? 32'd1 : 32'd0);
    chk("wait_cnt", 32'(dbg_wait_cnt), m_waited);
    if (s.rst) begin
      m_waited = 0; m_tmo = 0; m_bub = 0; m_red = 0; m_frz = 0;
    end else begin
      if (abort) m_tmo = 1;
      m_waited = freeze ? m_waited + 1 : 0;
      if (freeze) m_frz = sat(m_frz);
      if (!freeze && s.br) m_red = sat(m_red);
      if (!freeze && !s.br && lu) m_bub = sat(m_bub);
    end
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    step(s);
  endtask

  task automatic add_vec(input string name, input stim_t s, input logic [9:0] e);
    vec_t v;
    v.name = name; v.s = s; v.exp_ctrl = e;
    vecs.push_back(v);
  endtask

  initial begin
    stim_t s;
    stim_t prev;
    int    r;
    total = 0; bad = 0;
    m_waited = 0; m_tmo = 0; m_bub = 0; m_red = 0; m_frz = 0;
    s = idle();
    s.rst = 1'b1;
    apply(s);
    repeat (2) @(posedge clk);

    // reset state
    do_reset();
    step(idle());
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_bubble", 32'(bus.bubble_count), 32'd0);
    chk("rst_tmo", 32'(bus.dmem_timeout), 32'd0);

    // directed vector table
    s = idle();                                                          add_vec("v_idle", s, C_NONE);
    s = idle(); s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1;           add_vec("v_lu_rs1", s, C_LU);
    s = idle(); s.ex_mr = 1; s.ex_rd = 0; s.rs1 = 0; s.u1 = 1;           add_vec("v_lu_x0", s, C_NONE);
    s = idle(); s.ex_mr = 1; s.ex_rd = 9; s.rs2 = 9; s.u2 = 1;           add_vec("v_lu_rs2", s, C_LU);
    s = idle(); s.ex_mr = 1; s.ex_rd = 7; s.rs1 = 7; s.u1 = 0;           add_vec("v_lu_unused", s, C_NONE);
    s = idle(); s.ex_mr = 0; s.ex_rd = 7; s.rs1 = 7; s.u1 = 1;           add_vec("v_no_load", s, C_NONE);
    s = idle(); s.imem_rdy = 0;                                          add_vec("v_imem", s, C_IM);
    s = idle(); s.br = 1; s.tgt = 32'h100; s.imem_rdy = 0;
    s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1;                       add_vec("v_branch", s, C_BR);
    s = idle(); s.ex_mr = 1; s.ex_rd = 3; s.rs1 = 3; s.u1 = 1; s.imem_rdy = 0;
                                                                         add_vec("v_lu_over_imem", s, C_LU);
    s = idle(); s.m_rd = 1; s.dmem_rdy = 0; s.br = 1; s.tgt = 32'h200;  add_vec("v_freeze_br", s, C_FZ);
    s = idle();                                                          add_vec("v_lost_acc", s, C_NONE);
    s = idle(); s.m_wr = 1;                                              add_vec("v_store_rdy", s, C_NONE);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].s);
      chk(vecs[i].name, 32'(w_ctrl), 32'(vecs[i].exp_ctrl));
    end
    step(idle());
    chk("tbl_redirects", 32'(bus.redirect_count), 32'd1);
    chk("tbl_state", 32'(dbg_state), 32'd0);

    // load-use bumps the bubble counter once
    do_reset();
    s = idle(); s.ex_mr = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1;
    step(s);
    chk("lu_ctrl", 32'(w_ctrl), 32'(C_LU));
    step(idle());
    chk("lu_bubble", 32'(bus.bubble_count), 32'd1);

    // data wait: 3 freeze cycles then completion
    do_reset();
    s = idle(); s.m_rd = 1; s.dmem_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step(s);
      chk("dw_freeze", 32'(w_ctrl), 32'(C_FZ));
    end
    s.dmem_rdy = 1;
    step(s);
    chk("dw_release", 32'(w_ctrl), 32'(C_NONE));
    step(idle());
    chk("dw_state", 32'(dbg_state), 32'd0);
    chk("dw_frz_cnt", 32'(bus.freeze_count), 32'd3);

    // timeout: T freeze cycles, one abort cycle, then a sticky flag
    do_reset();
    s = idle(); s.m_rd = 1; s.dmem_rdy = 0;
    for (int i = 0; i < T; i++) begin
      step(s);
      chk("to_freeze", 32'(w_ctrl), 32'(C_FZ));
    end
    step(s);
    chk("to_abort", 32'(w_ctrl), 32'(C_AB));
    chk("to_flag_early", 32'(bus.dmem_timeout), 32'd0);
    step(idle());
    chk("to_flag", 32'(bus.dmem_timeout), 32'd1);
    chk("to_frz_sat", 32'(bus.freeze_count), 32'd3);
    repeat (3) step(idle());
    chk("to_sticky", 32'(bus.dmem_timeout), 32'd1);
    do_reset();
    step(idle());
    chk("to_cleared", 32'(bus.dmem_timeout), 32'd0);

    // ready arriving exactly at the limit is a completion
    s = idle(); s.m_wr = 1; s.dmem_rdy = 0;
    for (int i = 0; i < T; i++) step(s);
    s.dmem_rdy = 1;
    step(s);
    chk("lim_ctrl", 32'(w_ctrl), 32'(C_NONE));
    step(idle());
    chk("lim_flag", 32'(bus.dmem_timeout), 32'd0);

    // reset mid-DWAIT abandons the wait
    s = idle(); s.m_rd = 1; s.dmem_rdy = 0;
    step(s);
    step(s);
    s.rst = 1;
    step(s);
    chk("rw_ctrl", 32'(w_ctrl), 32'(C_NONE));
    step(idle());
    chk("rw_state", 32'(dbg_state), 32'd0);
    chk("rw_wait", 32'(dbg_wait_cnt), 32'd0);
    chk("rw_frz_cnt", 32'(bus.freeze_count), 32'd0);

    // saturation: 5 redirects into a 2-bit counter
    do_reset();
    s = idle(); s.br = 1; s.tgt = 32'h0000_0100;
    for (int i = 0; i < 5; i++) step(s);
    step(idle());
    chk("sat_redirect", 32'(bus.redirect_count), 32'd3);

    // random traffic against the model
    do_reset();
    prev = idle();
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 49) == 0);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.ex_mr = 1'($urandom_range(0, 1));
      s.ex_rd = 5'($urandom_range(0, 7));
      s.br    = ($urandom_range(0, 7) == 0);
      s.tgt   = $urandom;
      s.imem_rdy = ($urandom_range(0, 3) != 0);
      s.dmem_rdy = ($urandom_range(0, 3) == 0);
      if (m_waited > 0) begin
        s.m_rd = prev.m_rd;
        s.m_wr = prev.m_wr;
      end else begin
        r = $urandom_range(0, 5);
        s.m_rd = (r == 0);
        s.m_wr = (r == 1);
      end
      step(s);
      prev = s;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
